// File: rtl/apb_uart_regif.sv
// APB3 register front end for one UART channel: DATA/STATUS/CTRL/INT/BAUD/PARITY,
// a small TX FIFO with wait-state back-pressure, a 1-byte RX holding register and a maskable irq.
module apb_uart_regif #(
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [9:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        irq
);

    localparam int unsigned PTR_W  = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W  = $clog2(TX_DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    localparam logic [9:0] ADDR_DATA   = 10'h000;
    localparam logic [9:0] ADDR_STATUS = 10'h001;
    localparam logic [9:0] ADDR_CTRL   = 10'h002;
    localparam logic [9:0] ADDR_INT    = 10'h003;
    localparam logic [9:0] ADDR_BAUD   = 10'h004;
    localparam logic [9:0] ADDR_PARITY = 10'h005;

    // State and output registers
    logic [7:0]        fifo_q [TX_DEPTH];
    logic [7:0]        fifo_d [TX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [6:0]        ctrl_q, ctrl_d;
    logic [3:0]        int_q, int_d;
    logic [18:0]       baud_q, baud_d;
    logic [6:0]        parity_q, parity_d;
    logic [7:0]        rx_hold_q, rx_hold_d;
    logic              rx_full_q, rx_full_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              xfer_q, xfer_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              irq_q, irq_d;

    // Address decode and bus phase qualifiers
    logic is_data, is_status, is_ctrl, is_int, is_baud, is_parity, is_mapped;
    logic setup_c, access_c, complete_c, waiting_c;
    logic wr_ok_c, rd_ok_c, push_c, pop_c, drop_c;
    logic rx_load_c, rd_clr_c, overrun_evt_c;
    logic tx_full_c, tx_empty_c;
    logic [2:0]  cnt_disp_c;
    logic [31:0] rd_mux_c;
    logic [3:0]  int_set_c, int_clr_c;
    logic        pwdata_unused;

    assign is_data   = (PADDR == ADDR_DATA);
    assign is_status = (PADDR == ADDR_STATUS);
    assign is_ctrl   = (PADDR == ADDR_CTRL);
    assign is_int    = (PADDR == ADDR_INT);
    assign is_baud   = (PADDR == ADDR_BAUD);
    assign is_parity = (PADDR == ADDR_PARITY);
    assign is_mapped = (PADDR <= ADDR_PARITY);

    assign pwdata_unused = ^PWDATA[31:19];

    // xfer_q guards against an access phase that was never preceded by a setup phase
    assign setup_c    = PSEL & ~PENABLE;
    assign access_c   = PSEL & PENABLE & xfer_q;
    assign complete_c = access_c & pready_q;
    assign waiting_c  = access_c & ~pready_q;

    assign wr_ok_c = complete_c & PWRITE & ~pslverr_q;
    assign rd_ok_c = complete_c & ~PWRITE & ~pslverr_q;
    assign drop_c  = complete_c & PWRITE & is_data & pslverr_q;

    assign tx_full_c  = (count_q == CNT_W'(TX_DEPTH));
    assign tx_empty_c = (count_q == '0);
    assign push_c     = wr_ok_c & is_data;
    assign pop_c      = tx_valid_q & tx_ready;

    assign rx_load_c     = rx_valid & ctrl_q[5];
    assign rd_clr_c      = rd_ok_c & is_data;
    assign overrun_evt_c = rx_load_c & rx_full_q & ~rd_clr_c;

    assign cnt_disp_c = (32'(count_q) > 32'd7) ? 3'd7 : 3'(count_q);

    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ctrl_d       = ctrl_q;
        baud_d       = baud_q;
        parity_d     = parity_q;
        rx_hold_d    = rx_hold_q;
        rx_full_d    = rx_full_q;
        rx_overrun_d = rx_overrun_q;
        wait_cnt_d   = '0;
        xfer_d       = xfer_q;
        prdata_d     = '0;
        pready_d     = 1'b1;
        pslverr_d    = 1'b0;
        rd_mux_c     = '0;
        int_set_c    = '0;
        int_clr_c    = '0;

        // Register read mux, sampled at the end of the setup phase
        case (PADDR)
            ADDR_DATA:   rd_mux_c = {24'b0, rx_hold_q};
            ADDR_STATUS: rd_mux_c = {25'b0, cnt_disp_c, rx_overrun_q, tx_empty_c, rx_full_q, tx_full_c};
            ADDR_CTRL:   rd_mux_c = {25'b0, ctrl_q};
            ADDR_INT:    rd_mux_c = {28'b0, int_q};
            ADDR_BAUD:   rd_mux_c = {13'b0, baud_q};
            ADDR_PARITY: rd_mux_c = {25'b0, parity_q};
            default:     rd_mux_c = '0;
        endcase

        // TX FIFO: push and pop may coincide
        if (push_c) begin
            fifo_d[wr_ptr_q] = PWDATA[7:0];
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        // Bus handshake: PREADY/PSLVERR/PRDATA for the coming cycle
        if (!PSEL) begin
            xfer_d = 1'b0;
        end else if (setup_c) begin
            xfer_d   = 1'b1;
            prdata_d = PWRITE ? 32'h0 : rd_mux_c;
            if (!is_mapped) begin
                pslverr_d = 1'b1;
            end else if (PWRITE && is_data && (count_d == CNT_W'(TX_DEPTH))) begin
                pready_d = 1'b0;
            end
        end else if (waiting_c) begin
            prdata_d = prdata_q;
            if (count_d == CNT_W'(TX_DEPTH)) begin
                if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) begin
                    pslverr_d = 1'b1;
                end else begin
                    pready_d   = 1'b0;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
        end else if (complete_c) begin
            xfer_d = 1'b0;
        end

        if (wr_ok_c && is_ctrl) begin
            ctrl_d = PWDATA[6:0];
        end
        if (wr_ok_c && is_baud) begin
            baud_d = PWDATA[18:0];
        end
        if (wr_ok_c && is_parity) begin
            parity_d = PWDATA[6:0];
        end
        if (wr_ok_c && is_int) begin
            int_clr_c = PWDATA[3:0];
        end

        // RX holding register: a new byte beats a same-cycle read clear
        if (rx_load_c) begin
            rx_hold_d = rx_data;
        end
        rx_full_d    = rx_load_c | (rx_full_q & ~rd_clr_c);
        rx_overrun_d = overrun_evt_c | (rx_overrun_q & ~(rd_ok_c & is_status));

        int_set_c[0] = ~tx_empty_c & (count_d == '0);
        int_set_c[1] = rx_load_c;
        int_set_c[2] = drop_c;
        int_set_c[3] = overrun_evt_c;
        int_d        = (int_q & ~int_clr_c) | int_set_c;

        tx_valid_d = ctrl_d[4] & (count_d != '0);
        tx_data_d  = (count_d != '0) ? fifo_d[rd_ptr_d] : 8'h00;
        irq_d      = |(int_d & ctrl_d[3:0]);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int unsigned i = 0; i < TX_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ctrl_q       <= '0;
            int_q        <= '0;
            baud_q       <= '0;
            parity_q     <= '0;
            rx_hold_q    <= '0;
            rx_full_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
            wait_cnt_q   <= '0;
            xfer_q       <= 1'b0;
            prdata_q     <= '0;
            pready_q     <= 1'b1;
            pslverr_q    <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ctrl_q       <= ctrl_d;
            int_q        <= int_d;
            baud_q       <= baud_d;
            parity_q     <= parity_d;
            rx_hold_q    <= rx_hold_d;
            rx_full_q    <= rx_full_d;
            rx_overrun_q <= rx_overrun_d;
            wait_cnt_q   <= wait_cnt_d;
            xfer_q       <= xfer_d;
            prdata_q     <= prdata_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            irq_q        <= irq_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_apb_uart_regif.sv
// Directed bench for apb_uart_regif: register access, TX back-pressure and drop,
// RX overrun and load/clear collision, interrupts, unmapped access and mid-transfer reset.
module tb_apb_uart_regif;

    localparam logic [9:0] A_DATA   = 10'h000;
    localparam logic [9:0] A_STATUS = 10'h001;
    localparam logic [9:0] A_CTRL   = 10'h002;
    localparam logic [9:0] A_INT    = 10'h003;
    localparam logic [9:0] A_BAUD   = 10'h004;
    localparam logic [9:0] A_PARITY = 10'h005;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [9:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    apb_uart_regif #(.TX_DEPTH(4), .WAIT_MAX(15)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer, entered and left at posedge+1; cyc counts access cycles
    task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int cyc, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyc = 1;
        while (PREADY !== 1'b1 && cyc < 40) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [9:0] addr, input logic [31:0] data,
                            input int exp_cyc, input logic exp_err);
        logic [31:0] rd;
        int          cyc;
        logic        err;
        apb_xfer(1'b1, addr, data, rd, cyc, err);
        check({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " pslverr"}, 32'(err), 32'(exp_err));
    endtask

    task automatic do_read(input string tag, input logic [9:0] addr, input logic [31:0] exp_data,
                           input logic exp_err);
        logic [31:0] rd;
        int          cyc;
        logic        err;
        apb_xfer(1'b0, addr, 32'h0, rd, cyc, err);
        check({tag, " data"}, rd, exp_data);
        check({tag, " cycles"}, 32'(cyc), 32'd1);
        check({tag, " pslverr"}, 32'(err), 32'(exp_err));
    endtask

    task automatic rx_strobe(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        @(posedge PCLK); #1;
        rx_valid = 1'b0;
    endtask

    // Release tx_ready and expect four bytes (LSB first in 'bytes') on consecutive cycles
    task automatic drain(input string tag, input logic [31:0] bytes);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check({tag, " tx_valid"}, 32'(tx_valid), 32'd1);
            check({tag, " tx_data"}, 32'(tx_data), 32'(bytes[8*i +: 8]));
            @(posedge PCLK); #1;
        end
        check({tag, " tx_valid empty"}, 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        logic        err;

        // Reset values
        repeat (2) @(posedge PCLK);
        #1;
        check("rst PREADY", 32'(PREADY), 32'd1);
        check("rst PRDATA", PRDATA, 32'h0);
        check("rst PSLVERR", 32'(PSLVERR), 32'd0);
        check("rst tx_valid", 32'(tx_valid), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'h0);
        check("rst irq", 32'(irq), 32'd0);
        PRESETn = 1'b1;

        do_read("status after reset", A_STATUS, 32'h04, 1'b0);
        do_read("baud after reset", A_BAUD, 32'h0, 1'b0);
        check("idle PRDATA", PRDATA, 32'h0);
        check("idle irq", 32'(irq), 32'd0);

        // Plain RW registers
        do_write("wr ctrl", A_CTRL, 32'h3f, 1, 1'b0);
        do_write("wr baud", A_BAUD, 32'h10, 1, 1'b0);
        do_write("wr parity", A_PARITY, 32'h01, 1, 1'b0);
        do_read("rd ctrl", A_CTRL, 32'h3f, 1'b0);
        do_read("rd baud", A_BAUD, 32'h10, 1'b0);
        do_read("rd parity", A_PARITY, 32'h01, 1'b0);
        do_write("wr baud ones", A_BAUD, 32'hffff_ffff, 1, 1'b0);
        do_read("rd baud width", A_BAUD, 32'h0007_ffff, 1'b0);
        do_write("wr parity ones", A_PARITY, 32'hffff_ffff, 1, 1'b0);
        do_read("rd parity width", A_PARITY, 32'h7f, 1'b0);
        do_write("wr status ignored", A_STATUS, 32'hff, 1, 1'b0);
        do_read("rd status unchanged", A_STATUS, 32'h04, 1'b0);

        // Fill TX FIFO, then a fifth write times out and is dropped
        do_write("tx push 34", A_DATA, 32'h34, 1, 1'b0);
        check("tx head", 32'(tx_data), 32'h34);
        check("tx valid", 32'(tx_valid), 32'd1);
        do_write("tx push 35", A_DATA, 32'h35, 1, 1'b0);
        do_write("tx push 36", A_DATA, 32'h36, 1, 1'b0);
        do_write("tx push 37", A_DATA, 32'h37, 1, 1'b0);
        do_read("status full", A_STATUS, 32'h41, 1'b0);
        check("irq before drop", 32'(irq), 32'd0);
        do_write("tx blocked timeout", A_DATA, 32'h38, 16, 1'b1);
        check("irq after drop", 32'(irq), 32'd1);
        do_read("int drop", A_INT, 32'h4, 1'b0);
        do_read("status after drop", A_STATUS, 32'h41, 1'b0);
        drain("drain1", 32'h37363534);
        do_read("int empty+drop", A_INT, 32'h5, 1'b0);
        do_write("w1c drop only", A_INT, 32'h4, 1, 1'b0);
        do_read("int after w1c", A_INT, 32'h1, 1'b0);
        do_write("w1c all", A_INT, 32'hf, 1, 1'b0);

        // Blocked write released by a single pop during the wait
        do_write("tx push 40", A_DATA, 32'h40, 1, 1'b0);
        do_write("tx push 41", A_DATA, 32'h41, 1, 1'b0);
        do_write("tx push 42", A_DATA, 32'h42, 1, 1'b0);
        do_write("tx push 43", A_DATA, 32'h43, 1, 1'b0);
        fork
            apb_xfer(1'b1, A_DATA, 32'h44, rd, cyc, err);
            begin
                repeat (5) @(posedge PCLK);
                #1 tx_ready = 1'b1;
                @(posedge PCLK);
                #1 tx_ready = 1'b0;
            end
        join
        check("released write cycles", 32'(cyc), 32'd6);
        check("released write pslverr", 32'(err), 32'd0);
        do_read("status refilled", A_STATUS, 32'h41, 1'b0);
        do_read("int no drop", A_INT, 32'h0, 1'b0);
        drain("drain2", 32'h44434241);
        do_write("w1c empty", A_INT, 32'hf, 1, 1'b0);

        // RX path
        rx_strobe(8'hcd);
        do_read("rx data cd", A_DATA, 32'hcd, 1'b0);
        do_read("int rx", A_INT, 32'h2, 1'b0);
        check("irq rx", 32'(irq), 32'd1);
        do_read("status rx cleared", A_STATUS, 32'h04, 1'b0);
        rx_strobe(8'h11);
        rx_strobe(8'h22);
        do_read("status overrun", A_STATUS, 32'h0e, 1'b0);
        do_read("status overrun cleared", A_STATUS, 32'h06, 1'b0);
        do_read("rx data 22", A_DATA, 32'h22, 1'b0);
        do_read("int rx+ovr", A_INT, 32'ha, 1'b0);
        do_write("w1c rx", A_INT, 32'hf, 1, 1'b0);
        do_read("int cleared", A_INT, 32'h0, 1'b0);
        check("irq cleared", 32'(irq), 32'd0);

        // New byte arriving on the read-clear edge keeps rx_full set without overrun
        rx_strobe(8'h66);
        fork
            apb_xfer(1'b0, A_DATA, 32'h0, rd, cyc, err);
            begin
                @(posedge PCLK);
                #1 rx_valid = 1'b1; rx_data = 8'h77;
                @(posedge PCLK);
                #1 rx_valid = 1'b0;
            end
        join
        check("collide read data", rd, 32'h66);
        do_read("status load wins", A_STATUS, 32'h06, 1'b0);
        do_read("rx data 77", A_DATA, 32'h77, 1'b0);
        do_read("status rx empty", A_STATUS, 32'h04, 1'b0);
        do_write("w1c rx2", A_INT, 32'hf, 1, 1'b0);

        // Unmapped addresses
        do_read("rd unmapped 006", 10'h006, 32'h0, 1'b1);
        do_read("rd unmapped 3ff", 10'h3ff, 32'h0, 1'b1);
        do_write("wr unmapped 006", 10'h006, 32'hdead_beef, 1, 1'b1);
        do_read("ctrl untouched", A_CTRL, 32'h3f, 1'b0);

        // Reset during an access phase
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_BAUD; PWDATA = 32'h123;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESETn = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESETn = 1'b1;
        check("midrst PREADY", 32'(PREADY), 32'd1);
        check("midrst PSLVERR", 32'(PSLVERR), 32'd0);
        check("midrst PRDATA", PRDATA, 32'h0);
        check("midrst irq", 32'(irq), 32'd0);
        do_read("midrst baud", A_BAUD, 32'h0, 1'b0);
        do_read("midrst ctrl", A_CTRL, 32'h0, 1'b0);
        do_read("midrst parity", A_PARITY, 32'h0, 1'b0);
        do_read("midrst status", A_STATUS, 32'h04, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_uart_regif.md
# apb_uart_regif

APB3 responder that gives software its register view of one UART channel: data, status, control, interrupt, baud and parity registers, a 4-deep TX FIFO and a 1-byte RX holding register. It sits between the system APB bus (PSEL/PENABLE/PWRITE initiator) and the UART serial core. It decodes word addresses PADDR[11:2], inserts wait states when TX is blocked, and raises a maskable interrupt.

## Interface
- TX_DEPTH, 4: TX FIFO entries (power of two, 2..16)
- WAIT_MAX, 15: maximum wait states on a blocked DATA write before an error completion
- PCLK  in  1  sole clock, rising edge
- PRESETn  in  1  synchronous, active-low reset
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  10 [11:2]  word address
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer-complete
- PSLVERR  out  1  error response, valid when PREADY=1
- tx_data  out  8  byte to serial core
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  core accepts byte when tx_valid & tx_ready
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- irq  out  1  level interrupt

## Operation
- Register map (word address): 0x000 DATA, 0x001 STATUS, 0x002 CTRL, 0x003 INT, 0x004 BAUD, 0x005 PARITY. Any other address: reads return 0, writes are ignored, PSLVERR=1.
- DATA write: pushes PWDATA[7:0] to the TX FIFO. DATA read: returns {24'b0, rx_hold} and clears rx_full. Reading with rx_full=0 returns the last byte; no error.
- STATUS (RO, writes ignored, no error): [0] tx_full, [1] rx_full, [2] tx_empty, [3] rx_overrun, [6:4] TX FIFO count (saturating display), others 0.
- CTRL[6:0] RW, reset 0. [3:0] interrupt enables, [4] tx_en, [5] rx_en, [6] reserved RW.
- INT[3:0] sticky status, write-1-to-clear:
  - [0] TX FIFO became empty
  - [1] byte received
  - [2] TX write dropped
  - [3] RX overrun
- BAUD[18:0] and PARITY[6:0] are RW storage, reset 0, upper bits read 0. Fields go to the core as-is.
- TX path: tx_valid = tx_en & !tx_empty; tx_data = FIFO head. Pop on tx_valid & tx_ready. Push and pop in the same cycle leave the count unchanged. The pointers wrap modulo TX_DEPTH.
- RX path: rx_valid & rx_en loads rx_hold and sets rx_full and INT[1]. If rx_full is already set and is not cleared that cycle, it also sets rx_overrun and INT[3]; the new byte overwrites. If an RX load and a DATA-read clear occur in the same cycle, the load wins and rx_full stays 1. rx_overrun clears on a STATUS read.
- irq = |(INT[3:0] & CTRL[3:0]), registered.
- When a hardware set and a W1C clear hit the same INT bit in the same cycle, the set wins.

## Timing
- Setup phase: PSEL=1, PENABLE=0. Access phase: PSEL=1, PENABLE=1. A transfer completes on the rising edge where PSEL & PENABLE & PREADY.
- PRDATA is registered at the end of the setup phase and held stable through the access phase. It is 0 outside access phases.
- PREADY=1 in the first access cycle for all transfers except a DATA write with tx_full=1.
- Blocked write: PREADY stays 0 while tx_full.
  - If a slot frees, PREADY goes 1 in the next cycle and the push occurs on the completing edge.
  - After WAIT_MAX wait cycles: PREADY=1 and PSLVERR=1, the data is dropped, INT[2] is set.
- Register writes and the RX clear-on-read take effect on the completing edge.
- PSLVERR is 0 whenever PREADY=0 or no transfer is active.
- Reset values (PRESETn low at a rising edge):
  - PRDATA=0, PREADY=1, PSLVERR=0, tx_valid=0, tx_data=0, irq=0
  - FIFO empty; all registers, rx_hold and the flags 0
  - Any wait-state count is cleared
- Reset during an access phase aborts the transfer with no register side effect.

## Test plan
- After reset, read STATUS -> PRDATA=0x04 (tx_empty); read BAUD -> 0; irq=0; PREADY=1.
- Write CTRL=0x3f, BAUD=0x10, PARITY=0x01, then read back -> 0x3f, 0x10, 0x01. Each transfer takes exactly 2 cycles with PSLVERR=0.
- tx_en=1, tx_ready=0, write DATA 0x34,0x35,0x36,0x37 -> STATUS=0x41 (count 4, full). A fifth write -> 15 wait cycles, then PSLVERR=1, INT[2]=1, irq=1. Raising tx_ready -> bytes 0x34..0x37 in order, then INT[0]=1.
- With a 5th write pending, pulse tx_ready once during the wait -> the write completes the cycle after, PSLVERR=0, and the byte is queued.
- rx_en=1: rx_valid with 0xcd, read DATA -> 0xcd, INT[1]=1. Two strobes (0x11, 0x22) with no read -> DATA=0x22, STATUS[3]=1, INT[3]=1. Write INT=0xf -> INT=0, irq=0.
- Access address 0x006 -> PSLVERR=1, PRDATA=0. Assert reset mid-access -> PREADY=1, registers 0 on the next cycle.
